// File: rtl/tmds_word_packer_pkg.sv
// Shared defaults and width helpers for the TMDS word packer.
package tmds_pack_pkg;

    localparam int unsigned DEF_NUM_CH     = 3;
    localparam int unsigned DEF_SYM_W      = 10;
    localparam int unsigned DEF_PACK_RATIO = 2;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam logic [9:0]  DEF_IDLE_SYMBOL = 10'b1101010100;

    function automatic int unsigned phase_width(input int unsigned ratio);
        return (ratio > 1) ? int'($clog2(ratio)) : 1;
    endfunction

    function automatic int unsigned word_width(input int unsigned num_ch,
                                               input int unsigned sym_w,
                                               input int unsigned pack_ratio);
        return num_ch * pack_ratio * sym_w;
    endfunction

endpackage

// File: rtl/tmds_word_packer_if.sv
// Symbol input and packed-word output bus of the TMDS word packer.
interface tmds_word_packer_if
    import tmds_pack_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned SYM_W      = DEF_SYM_W,
    parameter int unsigned PACK_RATIO = DEF_PACK_RATIO
);
    localparam int unsigned SYM_BUS_W = NUM_CH * SYM_W;
    localparam int unsigned WORD_W    = word_width(NUM_CH, SYM_W, PACK_RATIO);

    logic [SYM_BUS_W-1:0] in_sym;
    logic                 in_valid;
    logic                 sync;
    logic [WORD_W-1:0]    out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_sym, in_valid, sync, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_sym, in_valid, sync, out_ready,
        output out_data, out_valid
    );

endinterface

// File: rtl/tmds_word_packer_sync_fifo.sv
// Single-clock show-ahead FIFO with registered fill level and sticky overflow/underflow flags.
module tmds_sync_fifo #(
    parameter int unsigned WIDTH = 60,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     txoutclk_internal,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     not_empty,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      fill_next;
    logic             empty, full, do_push, do_pop;

    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop    = pop && !empty;
        // A pop frees the head slot in the same edge, so a full FIFO can still take a word.
        do_push   = push && (!full || do_pop);
        fill_next = fill_level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        head_data = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge txoutclk_internal) begin
        if (reset) begin
            mem        <= '{default: '0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            not_empty  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            fill_level <= fill_next;
            not_empty  <= (fill_next != '0);
            if (push && full && !do_pop)
                overflow <= 1'b1;
            if (pop && empty)
                underflow <= 1'b1;
        end
    end

endmodule

// File: rtl/tmds_word_packer.sv
// Packs PACK_RATIO symbols per channel into one GT word and queues words in a show-ahead FIFO.
// Optional: define TMDS_PACK_IDLE_FILL_EN to accept in_valid=0 cycles as IDLE_SYMBOL.
module tmds_word_packer
    import tmds_pack_pkg::*;
#(
    parameter int unsigned      NUM_CH      = DEF_NUM_CH,
    parameter int unsigned      SYM_W       = DEF_SYM_W,
    parameter int unsigned      PACK_RATIO  = DEF_PACK_RATIO,
    parameter int unsigned      FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter logic [SYM_W-1:0] IDLE_SYMBOL = SYM_W'(DEF_IDLE_SYMBOL)
) (
    input  logic                                 txoutclk_internal,
    input  logic                                 reset,
    tmds_word_packer_if.slave                    bus,
    output logic [$clog2(FIFO_DEPTH):0]          fill_level,
    output logic [phase_width(PACK_RATIO)-1:0]   phase,
    output logic                                 overflow,
    output logic                                 underflow
);
    localparam int unsigned     PH_W      = phase_width(PACK_RATIO);
    localparam int unsigned     CH_W      = NUM_CH * SYM_W;
    localparam int unsigned     WORD_W    = word_width(NUM_CH, SYM_W, PACK_RATIO);
    localparam logic [PH_W-1:0] LAST_SLOT = PH_W'(PACK_RATIO - 1);

    logic              accept;
    logic              word_done;
    logic [CH_W-1:0]   sym_eff;
    logic [PH_W-1:0]   slot;
    logic [WORD_W-1:0] slots_q, slots_d;

    always_comb begin
        sym_eff = bus.in_valid ? bus.in_sym : {NUM_CH{IDLE_SYMBOL}};
`ifdef TMDS_PACK_IDLE_FILL_EN
        accept = 1'b1;
`else
        accept = bus.in_valid;
`endif
        slot      = bus.sync ? '0 : phase;
        word_done = accept && (slot == LAST_SLOT);
        // slots_d is the word including this cycle's symbol, so a completed word pushes in the same edge.
        slots_d   = bus.sync ? '0 : slots_q;
        if (accept) begin
            for (int unsigned c = 0; c < NUM_CH; c++)
                slots_d[(c*PACK_RATIO + 32'(slot))*SYM_W +: SYM_W] = sym_eff[c*SYM_W +: SYM_W];
        end
    end

    always_ff @(posedge txoutclk_internal) begin
        if (reset) begin
            phase   <= '0;
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
            if (word_done)
                phase <= '0;
            else if (accept)
                phase <= slot + 1'b1;
            else if (bus.sync)
                phase <= '0;
        end
    end

    tmds_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .txoutclk_internal (txoutclk_internal),
        .reset             (reset),
        .push              (word_done),
        .push_data         (slots_d),
        .pop               (bus.out_ready),
        .head_data         (bus.out_data),
        .not_empty         (bus.out_valid),
        .fill_level        (fill_level),
        .overflow          (overflow),
        .underflow         (underflow)
    );

endmodule
